sindoku_board_entry: RTL
========================

# sindoku_board_entry

Player board-entry stage for SINdoku, between the button debouncers and the solve/check state machine. It receives single-clock button pulses, moves a 9x9 cursor, and writes switch values into an 81-cell board register file. The board is handed to the solver through a lock handshake, with a read port and a write-back port. The cursor value and position drive the SSD and LED path in the top.

## Interface
- DIM, 9, board dimension (rows = columns = values)
- CELL_W, 4, bits per cell value (0 = empty)

Ports:
- Clk  in  1  system clock (100 MHz)
- Reset_n  in  1  asynchronous, active-low reset
- Up_Pulse, Down_Pulse, Left_Pulse, Right_Pulse  in  1 each  single-clock cursor pulses (debouncer SCEN)
- Write_Pulse  in  1  commit Val to the cell under the cursor
- Clear_Pulse  in  1  start a board-clear sweep
- Give  in  1  level; write marks the cell as given (fixed clue)
- Val  in  CELL_W  value from Sw3..Sw0
- Lock  in  1  level from the solver (q_Solve|q_Check); requests a frozen board
- Sv_Row, Sv_Col  in  4 each  solver read/write address
- Sv_We  in  1  solver write strobe
- Sv_Data  in  CELL_W  solver write data
- Rd_Data  out  CELL_W  registered cell value at (Sv_Row, Sv_Col)
- Row, Col  out  4 each  cursor position, 0..8
- Cur_Val  out  CELL_W  value under the cursor (combinational from registers)
- Cur_Given  out  1  given flag under the cursor
- Locked  out  1  board is frozen for the solver
- Err  out  1  sticky flag for a rejected write
- Filled  out  7  count of nonzero cells, 0..81

## Operation
- States:
  - EDIT: accepts cursor and write pulses.
  - CLEAR: sweeps index 0..80, zeroing value and given flag, one cell per cycle.
  - LOCKED: only the solver port is active.
- EDIT transitions:
  - Clear_Pulse -> CLEAR.
  - Otherwise, Lock=1 -> LOCKED.
- CLEAR: after index 80 is written, go to EDIT; if Lock=1 on that cycle, go to LOCKED.
- LOCKED: Lock=0 -> EDIT.
- Simultaneous events in EDIT, in priority order:
  - Clear_Pulse beats Write_Pulse, which beats moves; the cursor still moves on a write cycle.
  - Up beats Down; Left beats Right.
  - One vertical and one horizontal move may apply together.
- Cursor: Up decrements Row, Down increments Row, Left decrements Col, Right increments Col. The cursor saturates at 0 and 8 unless SINDOKU_WRAP_EN is defined.
- User write (EDIT only):
  - Val > 9: rejected, Err set.
  - Cell given and Give=0: rejected, Err set.
  - Otherwise the cell takes Val and its given flag takes (Give && Val != 0).
- Err clears on the next accepted write, on Clear_Pulse, and on reset.
- Solver write: accepted only in LOCKED, only when the target cell is not given and Sv_Data <= 9; otherwise it is silently ignored. Sv_We outside LOCKED is ignored.
- Filled tracks every accepted write:
  - +1 for zero -> nonzero.
  - −1 for nonzero -> zero.
  - unchanged otherwise.
  - Forced to 0 at the end of CLEAR.
- Pulses received in CLEAR or LOCKED are dropped, except that Write_Pulse in LOCKED sets Err.
- Row/Sv address > 8: reads return 0; writes are ignored.

## Timing
- Reset (async assert, sync release): state EDIT; Row=0, Col=0; all cells 0 and not given; Filled=0; Err=0; Rd_Data=0; Locked=0.
- Cursor pulse at cycle n -> Row/Col updated at n+1. Cur_Val and Cur_Given follow in the same cycle.
- Write_Pulse at n -> cell, Filled and Err updated at n+1.
- Rd_Data has 1-cycle latency from Sv_Row/Sv_Col. A solver write to the same address at n is visible on Rd_Data at n+2.
- CLEAR lasts exactly 81 cycles. Locked rises 1 cycle after Lock is sampled in EDIT or at the end of CLEAR, and falls 1 cycle after Lock=0.
- Reset mid-CLEAR or mid-LOCKED aborts immediately to the reset values.

## Configuration
- SINDOKU_WRAP_EN defined: the cursor wraps (Row 0 + Up -> 8, Col 8 + Right -> 0).
- SINDOKU_WRAP_EN undefined: the cursor saturates at the edges.

## Structure
- Package sindoku_pkg holds:
  - DIM and CELL_W constants.
  - IDX_W=7.
  - The state enum {EDIT, CLEAR, LOCKED}.
  - The cell index function row*9+col.
- Sub-module sindoku_cursor holds the Row/Col counter pair with move priority and wrap/saturate logic; the top's row/col registers move into it.

## Test plan
- Reset, then Right x3 and Down x2 -> Row=2, Col=3. Up x5 -> Row=0 (saturate build) or Row=6 (WRAP build).
- Cursor at (4,4), Val=7, Write_Pulse -> Cur_Val=7 and Filled=1 next cycle. Write Val=0 -> Filled=0.
- Write Val=5 with Give=1, then Val=3 with Give=0 -> Err=1 and the cell stays 5. Then Val=3 with Give=1 -> accepted and Err=0.
- Val=12 with Write_Pulse -> Err=1; board and Filled unchanged.
- Fill 10 cells, then Clear_Pulse -> Filled=0 after exactly 81 cycles; Up_Pulse during the sweep does not move the cursor.
- Lock=1: Sv_We on a given cell is ignored and on an empty cell writes 9; Rd_Data=9 two cycles later; Write_Pulse sets Err; Lock=0 -> Locked=0 next cycle.

Source files
------------

// File: rtl/sindoku_pkg.sv
// Shared constants, FSM state type and cell-index helper for the SINdoku board-entry stage.
package sindoku_pkg;

    localparam int unsigned DIM    = 9;
    localparam int unsigned CELL_W = 4;
    localparam int unsigned IDX_W  = 7;
    localparam int unsigned POS_W  = 4;
    localparam int unsigned CELLS  = DIM * DIM;

    localparam logic [POS_W-1:0]  POS_MAX = POS_W'(DIM - 1);
    localparam logic [CELL_W-1:0] VAL_MAX = CELL_W'(DIM);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(CELLS - 1);

    typedef enum logic [1:0] {
        EDIT,
        CLEAR,
        LOCKED
    } state_t;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [POS_W-1:0] row,
                                                  input logic [POS_W-1:0] col);
        return IDX_W'(row) * IDX_W'(DIM) + IDX_W'(col);
    endfunction

endpackage

// File: rtl/sindoku_cursor.sv
// 9x9 cursor counter pair with Up>Down / Left>Right priority.
// SINDOKU_WRAP_EN defined: cursor wraps at the edges; otherwise it saturates.
module sindoku_cursor
    import sindoku_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    output logic [POS_W-1:0] row,
    output logic [POS_W-1:0] col
);

    logic [POS_W-1:0] row_nxt;
    logic [POS_W-1:0] col_nxt;

    function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
`ifdef SINDOKU_WRAP_EN
        return (p == '0) ? POS_MAX : p - POS_W'(1);
`else
        return (p == '0) ? '0 : p - POS_W'(1);
`endif
    endfunction

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
`ifdef SINDOKU_WRAP_EN
        return (p == POS_MAX) ? '0 : p + POS_W'(1);
`else
        return (p == POS_MAX) ? POS_MAX : p + POS_W'(1);
`endif
    endfunction

    always_comb begin
        row_nxt = row;
        col_nxt = col;
        if (en) begin
            if (up)        row_nxt = pos_dec(row);
            else if (down) row_nxt = pos_inc(row);
            if (left)       col_nxt = pos_dec(col);
            else if (right) col_nxt = pos_inc(col);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= row_nxt;
            col <= col_nxt;
        end
    end

endmodule

// File: rtl/sindoku_board_entry.sv
// SINdoku board-entry stage: cursor, 81-cell board, clear sweep and solver lock port.
// Build option: SINDOKU_WRAP_EN (cursor wraps instead of saturating, in sindoku_cursor).
module sindoku_board_entry
    import sindoku_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Up_Pulse,
    input  logic              Down_Pulse,
    input  logic              Left_Pulse,
    input  logic              Right_Pulse,
    input  logic              Write_Pulse,
    input  logic              Clear_Pulse,
    input  logic              Give,
    input  logic [CELL_W-1:0] Val,
    input  logic              Lock,
    input  logic [3:0]        Sv_Row,
    input  logic [3:0]        Sv_Col,
    input  logic              Sv_We,
    input  logic [CELL_W-1:0] Sv_Data,
    output logic [CELL_W-1:0] Rd_Data,
    output logic [3:0]        Row,
    output logic [3:0]        Col,
    output logic [CELL_W-1:0] Cur_Val,
    output logic              Cur_Given,
    output logic              Locked,
    output logic              Err,
    output logic [6:0]        Filled
);

    state_t            state, state_nxt;
    logic [CELL_W-1:0] cell_val   [CELLS];
    logic              cell_given [CELLS];
    logic [IDX_W-1:0]  clr_idx;

    logic [IDX_W-1:0]  cur_idx, sv_idx, wr_idx;
    logic              sv_ok, mv_en;
    logic              wr_en, wr_given, track;
    logic [CELL_W-1:0] wr_val, old_val;
    logic              err_set, err_clr, filled_clr;
    logic              fill_inc, fill_dec;

    sindoku_cursor u_cursor (
        .clk   (Clk),
        .rst_n (Reset_n),
        .en    (mv_en),
        .up    (Up_Pulse),
        .down  (Down_Pulse),
        .left  (Left_Pulse),
        .right (Right_Pulse),
        .row   (Row),
        .col   (Col)
    );

    assign cur_idx   = cell_idx(Row, Col);
    assign sv_ok     = (Sv_Row <= POS_MAX) && (Sv_Col <= POS_MAX);
    assign sv_idx    = sv_ok ? cell_idx(Sv_Row, Sv_Col) : '0;
    assign Cur_Val   = cell_val[cur_idx];
    assign Cur_Given = cell_given[cur_idx];
    assign Locked    = (state == LOCKED);

    // One board write per cycle at most: user in EDIT, sweep in CLEAR, solver in LOCKED.
    always_comb begin
        state_nxt  = state;
        mv_en      = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = cur_idx;
        wr_val     = '0;
        wr_given   = 1'b0;
        track      = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        filled_clr = 1'b0;
        case (state)
            EDIT: begin
                if (Clear_Pulse) begin
                    state_nxt = CLEAR;
                    err_clr   = 1'b1;
                end else begin
                    mv_en = 1'b1;
                    if (Lock) state_nxt = LOCKED;
                    if (Write_Pulse) begin
                        if ((Val > VAL_MAX) || (cell_given[cur_idx] && !Give)) begin
                            err_set = 1'b1;
                        end else begin
                            wr_en    = 1'b1;
                            track    = 1'b1;
                            wr_val   = Val;
                            wr_given = Give && (Val != '0);
                            err_clr  = 1'b1;
                        end
                    end
                end
            end
            CLEAR: begin
                wr_en  = 1'b1;
                wr_idx = clr_idx;
                if (clr_idx == IDX_MAX) begin
                    filled_clr = 1'b1;
                    state_nxt  = Lock ? LOCKED : EDIT;
                end
            end
            LOCKED: begin
                if (!Lock) state_nxt = EDIT;
                if (Write_Pulse) err_set = 1'b1;
                if (Sv_We && sv_ok && !cell_given[sv_idx] && (Sv_Data <= VAL_MAX)) begin
                    wr_en  = 1'b1;
                    track  = 1'b1;
                    wr_idx = sv_idx;
                    wr_val = Sv_Data;
                end
            end
            default: state_nxt = EDIT;
        endcase
    end

    assign old_val  = cell_val[wr_idx];
    assign fill_inc = track && (old_val == '0) && (wr_val != '0);
    assign fill_dec = track && (old_val != '0) && (wr_val == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= EDIT;
            clr_idx <= '0;
            Filled  <= '0;
            Err     <= 1'b0;
            Rd_Data <= '0;
            for (int unsigned i = 0; i < CELLS; i++) begin
                cell_val[i]   <= '0;
                cell_given[i] <= 1'b0;
            end
        end else begin
            state   <= state_nxt;
            clr_idx <= (state == CLEAR) ? clr_idx + IDX_W'(1) : '0;
            if (wr_en) begin
                cell_val[wr_idx]   <= wr_val;
                cell_given[wr_idx] <= wr_given;
            end
            if (filled_clr)    Filled <= '0;
            else if (fill_inc) Filled <= Filled + 7'd1;
            else if (fill_dec) Filled <= Filled - 7'd1;
            if (err_set)      Err <= 1'b1;
            else if (err_clr) Err <= 1'b0;
            Rd_Data <= sv_ok ? cell_val[sv_idx] : '0;
        end
    end

endmodule
